// File: rtl/dual_ram_arb.sv
// dual_ram_arb
// Arbiter and sequencer that lets two clients share one port of the dual-port
// RAM. One single-word access is issued per cycle. Read data is routed back to
// the client that issued the read.
//
// Ports:
//   sclk, srst_n            clock, asynchronous active-low reset
//   reqN, weN, addrN,       client N request (held until gntN), write flag,
//   wdataN                  address and write data
//   gntN                    one-cycle pulse: client N's access is on the RAM port
//   rvldN, rdataN           one-cycle read-return pulse; rdataN holds its value
//   ram_en, ram_we,         RAM port controls driven for the granted access
//   ram_addr, ram_wdata
//   ram_rdata               RAM read data, valid RD_LAT cycles after a read enable
module dual_ram_arb #(
  parameter int AW        = 8,
  parameter int DW        = 16,
  parameter int RD_LAT    = 1,
  parameter int MAX_BURST = 4
) (
  input  logic          sclk,
  input  logic          srst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvld0,
  output logic          rvld1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  // Last allowed index of a contended burst; the grant after it goes to the other client.
  localparam logic [3:0] BURST_LIM = 4'(MAX_BURST - 1);

  state_t     state, state_nxt;
  logic       ptr, ptr_nxt;
  logic [3:0] burst_cnt, burst_nxt;
  logic       grant0, grant1;

  // Return pipeline: stage 0 is loaded in the cycle after the read is on the
  // port, and the output register below is the final stage.
  logic [RD_LAT-1:0] pipe_vld;
  logic [RD_LAT-1:0] pipe_id;

  // Arbitration state register.
  always_ff @(posedge sclk or negedge srst_n) begin
    if (!srst_n) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      burst_cnt <= burst_nxt;
    end
  end

  // Grant decision. An ownership change always clears the burst count and
  // points the priority at the client that lost. A client requesting alone
  // keeps the port without counting against its burst.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    burst_nxt = burst_cnt;
    grant0    = 1'b0;
    grant1    = 1'b0;
    case (state)
      IDLE: begin
        if (req0 && (!req1 || !ptr)) begin
          grant0    = 1'b1;
          state_nxt = OWN0;
          burst_nxt = '0;
          ptr_nxt   = 1'b1;
        end else if (req1) begin
          grant1    = 1'b1;
          state_nxt = OWN1;
          burst_nxt = '0;
          ptr_nxt   = 1'b0;
        end
      end
      OWN0: begin
        if (req0 && (!req1 || burst_cnt < BURST_LIM)) begin
          grant0 = 1'b1;
          if (req1) burst_nxt = burst_cnt + 4'd1;
        end else if (req1) begin
          grant1    = 1'b1;
          state_nxt = OWN1;
          burst_nxt = '0;
          ptr_nxt   = 1'b0;
        end else begin
          state_nxt = IDLE;
          burst_nxt = '0;
        end
      end
      OWN1: begin
        if (req1 && (!req0 || burst_cnt < BURST_LIM)) begin
          grant1 = 1'b1;
          if (req0) burst_nxt = burst_cnt + 4'd1;
        end else if (req0) begin
          grant0    = 1'b1;
          state_nxt = OWN0;
          burst_nxt = '0;
          ptr_nxt   = 1'b1;
        end else begin
          state_nxt = IDLE;
          burst_nxt = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        burst_nxt = '0;
      end
    endcase
  end

  // Issue register: the winning client's access appears on the RAM port
  // together with its grant pulse. Idle cycles drive zeros.
  always_ff @(posedge sclk or negedge srst_n) begin
    if (!srst_n) begin
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      gnt0      <= grant0;
      gnt1      <= grant1;
      ram_en    <= grant0 | grant1;
      ram_we    <= grant0 ? we0 : (grant1 & we1);
      ram_addr  <= grant0 ? addr0 : (grant1 ? addr1 : '0);
      ram_wdata <= grant0 ? wdata0 : (grant1 ? wdata1 : '0);
    end
  end

  // Track each issued read and its client. gnt1 identifies the issuer.
  always_ff @(posedge sclk or negedge srst_n) begin
    if (!srst_n) begin
      pipe_vld <= '0;
      pipe_id  <= '0;
    end else begin
      pipe_vld[0] <= ram_en & ~ram_we;
      pipe_id[0]  <= gnt1;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_id[i]  <= pipe_id[i-1];
      end
    end
  end

  // The last stage lines up with valid RAM data; capture it for the owner.
  always_ff @(posedge sclk or negedge srst_n) begin
    if (!srst_n) begin
      rvld0  <= 1'b0;
      rvld1  <= 1'b0;
      rdata0 <= '0;
      rdata1 <= '0;
    end else begin
      rvld0 <= pipe_vld[RD_LAT-1] & ~pipe_id[RD_LAT-1];
      rvld1 <= pipe_vld[RD_LAT-1] & pipe_id[RD_LAT-1];
      if (pipe_vld[RD_LAT-1] && !pipe_id[RD_LAT-1]) rdata0 <= ram_rdata;
      if (pipe_vld[RD_LAT-1] && pipe_id[RD_LAT-1])  rdata1 <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_dual_ram_arb.sv
// Directed testbench for dual_ram_arb with default parameters (RD_LAT=1,
// MAX_BURST=4), attached to a small write-first RAM model with one cycle of
// read latency.
module tb_dual_ram_arb;

  logic        sclk;
  logic        srst_n;
  logic        req0, req1, we0, we1;
  logic [7:0]  addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        gnt0, gnt1, rvld0, rvld1;
  logic [15:0] rdata0, rdata1;
  logic        ram_en, ram_we;
  logic [7:0]  ram_addr;
  logic [15:0] ram_wdata, ram_rdata;

  logic [15:0] mem [256];

  int testCount = 0;
  int failCount = 0;

  dual_ram_arb dut (
    .sclk      (sclk),
    .srst_n    (srst_n),
    .req0      (req0),
    .req1      (req1),
    .we0       (we0),
    .we1       (we1),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .rvld0     (rvld0),
    .rvld1     (rvld1),
    .rdata0    (rdata0),
    .rdata1    (rdata1),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  // 10 ns system clock.
  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  // Write-first RAM port with one cycle of read latency.
  always @(posedge sclk) begin
    if (ram_en) begin
      if (ram_we) begin
        mem[ram_addr] <= ram_wdata;
        ram_rdata     <= ram_wdata;
      end else begin
        ram_rdata <= mem[ram_addr];
      end
    end
  end

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  // Drive both clients' request inputs.
  task automatic applyStimulus(input logic r0, input logic w0, input logic [7:0] a0,
                               input logic [15:0] d0, input logic r1, input logic w1,
                               input logic [7:0] a1, input logic [15:0] d1);
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
  endtask

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Pulse reset for two cycles with the clients idle.
  task automatic doReset();
    srst_n = 1'b0;
    applyStimulus(0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000);
    tick();
    tick();
    srst_n = 1'b1;
  endtask

  // Directed scenarios, each with its expected values worked out by hand.
  initial begin
    logic expOne;
    srst_n = 1'b1;
    applyStimulus(1, 0, 8'h00, 16'h0000, 1, 0, 8'h00, 16'h0000);
    #2 srst_n = 1'b0;

    // Reset held with both requests high: no grants, all outputs quiet.
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("reset gnt0", gnt0, 0);
      checkOutput("reset gnt1", gnt1, 0);
      checkOutput("reset ram_en", ram_en, 0);
    end
    checkOutput("reset rvld0", rvld0, 0);
    checkOutput("reset rdata1", rdata1, 0);
    srst_n = 1'b1;
    tick();
    checkOutput("first gnt0", gnt0, 1);
    checkOutput("first gnt1", gnt1, 0);

    // Client 0 writes 0x10 = 0x1234, then reads it back.
    doReset();
    applyStimulus(1, 1, 8'h10, 16'h1234, 0, 0, 8'h00, 16'h0000);
    tick();
    checkOutput("wr gnt0", gnt0, 1);
    checkOutput("wr ram_en", ram_en, 1);
    checkOutput("wr ram_we", ram_we, 1);
    checkOutput("wr ram_addr", ram_addr, 8'h10);
    checkOutput("wr ram_wdata", ram_wdata, 16'h1234);
    applyStimulus(1, 0, 8'h10, 16'h0000, 0, 0, 8'h00, 16'h0000);
    tick();
    checkOutput("rd gnt0", gnt0, 1);
    checkOutput("rd ram_we", ram_we, 0);
    checkOutput("rd ram_addr", ram_addr, 8'h10);
    applyStimulus(0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000);
    tick();
    checkOutput("idle ram_en", ram_en, 0);
    checkOutput("idle ram_we", ram_we, 0);
    checkOutput("early rvld0", rvld0, 0);
    tick();
    checkOutput("rd rvld0", rvld0, 1);
    checkOutput("rd rdata0", rdata0, 16'h1234);
    checkOutput("rd rvld1", rvld1, 0);
    tick();
    checkOutput("rvld0 pulse", rvld0, 0);
    checkOutput("rdata0 hold", rdata0, 16'h1234);

    // Both clients requesting continuously: bursts of four, port always busy.
    doReset();
    applyStimulus(1, 0, 8'h20, 16'h0000, 1, 0, 8'h20, 16'h0000);
    for (int i = 0; i < 10; i++) begin
      tick();
      expOne = ((i / 4) % 2) == 1;
      checkOutput($sformatf("contend gnt1 %0d", i), gnt1, expOne);
      checkOutput($sformatf("contend gnt0 %0d", i), gnt0, !expOne);
      checkOutput($sformatf("contend ram_en %0d", i), ram_en, 1);
    end

    // Load 0x01 = 0xAAAA and 0x02 = 0x5555, then read both back to back.
    doReset();
    applyStimulus(1, 1, 8'h01, 16'hAAAA, 1, 1, 8'h02, 16'h5555);
    tick();
    checkOutput("preload gnt0", gnt0, 1);
    applyStimulus(0, 0, 8'h00, 16'h0000, 1, 1, 8'h02, 16'h5555);
    tick();
    checkOutput("preload gnt1", gnt1, 1);
    applyStimulus(1, 0, 8'h01, 16'h0000, 1, 0, 8'h02, 16'h0000);
    tick();
    checkOutput("ilv gnt1", gnt1, 1);
    checkOutput("ilv addr1", ram_addr, 8'h02);
    applyStimulus(1, 0, 8'h01, 16'h0000, 0, 0, 8'h00, 16'h0000);
    tick();
    checkOutput("ilv gnt0", gnt0, 1);
    checkOutput("ilv addr0", ram_addr, 8'h01);
    applyStimulus(0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000);
    tick();
    checkOutput("ilv rvld1", rvld1, 1);
    checkOutput("ilv rdata1", rdata1, 16'h5555);
    checkOutput("ilv rvld0 quiet", rvld0, 0);
    tick();
    checkOutput("ilv rvld0", rvld0, 1);
    checkOutput("ilv rdata0", rdata0, 16'hAAAA);
    checkOutput("ilv rvld1 quiet", rvld1, 0);

    // Client 1 releases after two grants; client 0 then gets a fresh burst.
    doReset();
    applyStimulus(0, 0, 8'h00, 16'h0000, 1, 0, 8'h30, 16'h0000);
    tick();
    checkOutput("rel gnt1 a", gnt1, 1);
    applyStimulus(1, 0, 8'h31, 16'h0000, 1, 0, 8'h30, 16'h0000);
    tick();
    checkOutput("rel gnt1 b", gnt1, 1);
    applyStimulus(1, 0, 8'h31, 16'h0000, 0, 0, 8'h00, 16'h0000);
    tick();
    checkOutput("rel handover gnt0", gnt0, 1);
    checkOutput("rel handover gnt1", gnt1, 0);
    applyStimulus(1, 0, 8'h31, 16'h0000, 1, 0, 8'h30, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("rel burst gnt0 %0d", i), gnt0, 1);
    end
    applyStimulus(0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000);
    tick();
    checkOutput("rel idle ram_en", ram_en, 0);
    checkOutput("rel idle gnt0", gnt0, 0);
    checkOutput("rel idle gnt1", gnt1, 0);

    // Reset one cycle after a read grant: the read must never return.
    doReset();
    applyStimulus(1, 0, 8'h10, 16'h0000, 0, 0, 8'h00, 16'h0000);
    tick();
    checkOutput("rst-rd gnt0", gnt0, 1);
    applyStimulus(0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 16'h0000);
    tick();
    srst_n = 1'b0;
    tick();
    srst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput($sformatf("rst-rd rvld0 %0d", i), rvld0, 0);
      checkOutput($sformatf("rst-rd rdata0 %0d", i), rdata0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
